// File: rtl/led_pkg.sv
// Shared constants, types and helpers for the LED pattern engine.
package led_pkg;

    // Pattern select codes
    localparam logic [2:0] MODE_SYNC    = 3'd0;
    localparam logic [2:0] MODE_CHAIN   = 3'd1;
    localparam logic [2:0] MODE_PAIR    = 3'd2;
    localparam logic [2:0] MODE_CENTER  = 3'd3;
    localparam logic [2:0] MODE_BOUNCE  = 3'd4;
    localparam logic [2:0] MODE_REVERSE = 3'd5;
    localparam logic [2:0] MODE_FILL    = 3'd6;
    localparam logic [2:0] MODE_BLINK   = 3'd7;

    // Widest bank supported; bank patterns are built at this width then sliced
    localparam int unsigned ONEHOT_W = 16;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // One-hot vector with bit idx set, or all zero if idx falls outside width
    function automatic logic [ONEHOT_W-1:0] bank_onehot(input int width, input int idx);
        logic [ONEHOT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ONEHOT_W); i++) begin
            r[i] = (i < width) && (i == idx);
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the board switches and the LED pattern engine.
interface led_pattern_engine_if #(
    parameter int unsigned LED_W = 24
);
    logic [2:0]       mode;
    logic [2:0]       speed;
    logic             pause;
    logic [LED_W-1:0] led;
    logic             tick;

    // Switch side drives controls and observes the LEDs
    modport master (
        output mode,
        output speed,
        output pause,
        input  led,
        input  tick
    );

    // Engine side
    modport slave (
        input  mode,
        input  speed,
        input  pause,
        output led,
        output tick
    );
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle step strobe every max(DIV >> speed, 1) cycles.
module led_tick_gen #(
    parameter int unsigned DIV = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] speed,
    input  logic       pause,
    input  logic       restart,
    output logic       step
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   shifted;
    logic [31:0]   period_m1;

    // Period from speed select; >= compare lets a speed change take effect at once
    always_comb begin
        shifted   = DIV >> speed;
        period_m1 = (shifted > 32'd1) ? (shifted - 32'd1) : 32'd0;
        step      = !restart && !pause && (32'(cnt_q) >= period_m1);

        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (pause) begin
            cnt_d = cnt_q;
        end else if (step) begin
            cnt_d = '0;
        end else begin
            // cnt_q < period_m1 <= DIV-1 here, so the increment cannot overflow
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED chase/pattern generator over BANKS x BANK_W LEDs treated as one chain.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int unsigned BANKS  = 3,
    parameter int unsigned BANK_W = 8,
    parameter int unsigned DIV    = 20_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_engine_if.slave  bus
);

    localparam int unsigned L  = BANKS * BANK_W;
    localparam int unsigned PW = $clog2(L + 1);
    localparam int          LI = int'(L);
    localparam int          BW = int'(BANK_W);

    logic [2:0]          mode_q;
    logic [PW-1:0]       pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic [L-1:0]        led_q, led_d;
    logic                tick_q, tick_d;
    logic                mode_chg;
    logic                step;
    logic [PW-1:0]       last;
    logic [L-1:0]        pat;
    logic [ONEHOT_W-1:0] oh_a, oh_b;
    int                  p;
    int                  pb;

    assign mode_chg = (bus.mode != mode_q);

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .speed   (bus.speed),
        .pause   (bus.pause),
        .restart (mode_chg),
        .step    (step)
    );

    // Highest position before wrap for the current (non-bounce) mode
    always_comb begin
        last = '0;
        unique case (mode_q)
            MODE_SYNC, MODE_PAIR:      last = PW'(BANK_W - 1);
            MODE_CHAIN, MODE_REVERSE:  last = PW'(L - 1);
            MODE_BOUNCE:               last = PW'(L - 1);
            MODE_CENTER:               last = PW'(L / 2 - 1);
            MODE_FILL:                 last = PW'(L);
            MODE_BLINK:                last = PW'(1);
        endcase
    end

    // Next position/direction; a mode change restarts at step 0 and beats a step
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (mode_chg) begin
            pos_d = '0;
            dir_d = DirUp;
        end else if (step) begin
            if (mode_q == MODE_BOUNCE) begin
                if (dir_q == DirUp) begin
                    if (pos_q == PW'(L - 1)) begin
                        pos_d = PW'(L - 2);
                        dir_d = DirDown;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d = PW'(1);
                        dir_d = DirUp;
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end else begin
                pos_d = (pos_q >= last) ? '0 : (pos_q + PW'(1));
            end
        end
    end

    // Pattern for the incoming mode at the incoming position
    always_comb begin
        p    = int'(pos_d);
        pb   = (p + 2 >= BW) ? (p + 2 - BW) : (p + 2);
        oh_a = bank_onehot(BW, p);
        oh_b = bank_onehot(BW, pb);
        pat  = '0;
        unique case (bus.mode)
            MODE_SYNC: begin
                for (int b = 0; b < int'(BANKS); b++) begin
                    pat[b*BANK_W +: BANK_W] = oh_a[BANK_W-1:0];
                end
            end
            MODE_PAIR: begin
                for (int b = 0; b < int'(BANKS); b++) begin
                    pat[b*BANK_W +: BANK_W] = oh_a[BANK_W-1:0] | oh_b[BANK_W-1:0];
                end
            end
            MODE_CHAIN, MODE_BOUNCE: begin
                for (int i = 0; i < LI; i++) pat[i] = (i == p);
            end
            MODE_CENTER: begin
                for (int i = 0; i < LI; i++) pat[i] = (i == LI/2 - 1 - p) || (i == LI/2 + p);
            end
            MODE_REVERSE: begin
                for (int i = 0; i < LI; i++) pat[i] = (i == LI - 1 - p);
            end
            MODE_FILL: begin
                for (int i = 0; i < LI; i++) pat[i] = (i < p);
            end
            MODE_BLINK: begin
                pat = (p == 0) ? '1 : '0;
            end
        endcase
    end

    // Output next-state: pause freezes the LEDs unless the mode is being changed
    always_comb begin
        led_d  = (bus.pause && !mode_chg) ? led_q : pat;
        tick_d = step;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_SYNC;
            pos_q  <= '0;
            dir_q  <= DirUp;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed scoreboard bench for led_pattern_engine (3 banks x 8, DIV = 4).
module tb_led_pattern_engine;

    localparam int L  = 24;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [L-1:0] exp_q[$];

    always #5 clk = ~clk;

    led_pattern_engine_if #(.LED_W(L)) bus ();

    led_pattern_engine #(
        .BANKS  (3),
        .BANK_W (8),
        .DIV    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference pattern for mode m at step k, derived directly from k
    function automatic logic [L-1:0] model(input int m, input int k);
        logic [L-1:0] r;
        int q;
        r = '0;
        for (int i = 0; i < L; i++) begin
            case (m)
                0: r[i] = ((i % BW) == (k % BW));
                1: r[i] = (i == k % L);
                2: r[i] = ((i % BW) == (k % BW)) || ((i % BW) == ((k % BW) + 2) % BW);
                3: r[i] = (i == L/2 - 1 - (k % (L/2))) || (i == L/2 + (k % (L/2)));
                4: begin
                    q = k % (2*L - 2);
                    r[i] = (i == ((q < L) ? q : (2*L - 2 - q)));
                end
                5: r[i] = (i == L - 1 - (k % L));
                6: r[i] = (i < k % (L + 1));
                default: r[i] = ((k % 2) == 0);
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Wait for the next tick, then compare led with the scoreboard head and the gap
    task automatic wait_tick(input string tag, input int exp_gap);
        int n;
        logic [L-1:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < 200);
        check({tag, "-tick"}, 32'(bus.tick), 32'd1);
        check({tag, "-gap"}, 32'(n), 32'(exp_gap));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "-led"}, 32'(bus.led), 32'(e));
    endtask

    task automatic run_ticks(input string tag, input int m, input int k0, input int n,
                             input int gap);
        for (int k = k0; k < k0 + n; k++) exp_q.push_back(model(m, k));
        for (int j = 0; j < n; j++) wait_tick(tag, gap);
    endtask

    // Load of a new mode: step-0 pattern one edge later, with no tick
    task automatic set_mode(input string tag, input int m, input int spd);
        bus.mode  = 3'(m);
        bus.speed = 3'(spd);
        @(negedge clk);
        check({tag, "-load"}, 32'(bus.led), 32'(model(m, 0)));
        check({tag, "-load-tick"}, 32'(bus.tick), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.mode  = 3'd1;
        bus.speed = 3'd0;
        bus.pause = 1'b0;
        repeat (2) @(negedge clk);
        check("reset-led", 32'(bus.led), 32'd0);
        check("reset-tick", 32'(bus.tick), 32'd0);

        // Chain: full wrap after 24 ticks, then on to step 5
        rst = 1'b0;
        @(negedge clk);
        check("chain-load", 32'(bus.led), 32'h000001);
        check("chain-load-tick", 32'(bus.tick), 32'd0);
        run_ticks("chain", 1, 1, 29, 4);

        // Pause at step 5
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pause-led", 32'(bus.led), 32'h000020);
            check("pause-tick", 32'(bus.tick), 32'd0);
        end
        bus.pause = 1'b0;
        run_ticks("unpause", 1, 6, 1, 4);

        // Mode change mid-period to center
        repeat (2) @(negedge clk);
        set_mode("center", 3, 0);
        run_ticks("center", 3, 1, 12, 4);

        // Fill at period 2
        set_mode("fill", 6, 1);
        run_ticks("fill", 6, 1, 25, 2);

        // Bounce at period 1
        set_mode("bounce", 4, 2);
        run_ticks("bounce", 4, 1, 47, 1);

        // Remaining patterns; speed 7 exercises the period floor of 1
        set_mode("sync", 0, 1);
        run_ticks("sync", 0, 1, 10, 2);
        set_mode("pair", 2, 1);
        run_ticks("pair", 2, 1, 10, 2);
        set_mode("reverse", 5, 7);
        run_ticks("reverse", 5, 1, 26, 1);

        // Blink, then reset while all LEDs are lit
        set_mode("blink", 7, 0);
        run_ticks("blink", 7, 1, 2, 4);
        @(negedge clk);
        check("blink-hold", 32'(bus.led), 32'hFFFFFF);
        rst = 1'b1;
        @(negedge clk);
        check("midrst-led", 32'(bus.led), 32'd0);
        check("midrst-tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst-led", 32'(bus.led), 32'hFFFFFF);
        check("postrst-tick", 32'(bus.tick), 32'd0);
        run_ticks("postrst", 7, 1, 1, 4);

        // Speed raised while cnt already exceeds the new period-1
        repeat (2) @(negedge clk);
        bus.speed = 3'd1;
        run_ticks("speedup", 7, 2, 1, 1);
        run_ticks("speedup2", 7, 3, 1, 2);

        check("sb-drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
